// File: rtl/shared_ram_arbiter.sv
// Shares one single-port block RAM between a host (run=0) and NUM_CORES shader
// cores (run=1) with a same-cycle round-robin grant and one-cycle read returns.
module shared_ram_arbiter #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16,
  parameter int NUM_CORES     = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               run,
  input  logic [ADDRESS_WIDTH-1:0]           host_address,
  input  logic                               host_write,
  input  logic                               host_read,
  input  logic [WORD_WIDTH-1:0]              host_write_data,
  output logic [WORD_WIDTH-1:0]              host_read_data,
  output logic                               host_read_valid,
  input  logic [NUM_CORES-1:0]               core_req,
  input  logic [NUM_CORES-1:0]               core_write,
  input  logic [NUM_CORES*ADDRESS_WIDTH-1:0] core_address,
  input  logic [NUM_CORES*WORD_WIDTH-1:0]    core_write_data,
  output logic [NUM_CORES-1:0]               core_ack,
  output logic [WORD_WIDTH-1:0]              core_read_data,
  output logic [NUM_CORES-1:0]               core_read_valid,
  output logic [ADDRESS_WIDTH-3:0]           ram_address,
  output logic                               ram_write,
  output logic [WORD_WIDTH-1:0]              ram_write_data,
  input  logic [WORD_WIDTH-1:0]              ram_read_data,
  output logic [31:0]                        conflict_count
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [PTR_W:0] NUM_CORES_W = NUM_CORES[PTR_W:0];

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     rr_next;
  logic                 grant_valid;
  logic [PTR_W-1:0]     grant_idx;
  logic [NUM_CORES-1:0] grant_onehot;
  logic                 host_pend;
  logic [NUM_CORES-1:0] core_pend;
  logic [31:0]          conflict_cnt;
  logic                 conflict;
  logic                 addr_lsb_unused;

  // Round-robin scan starting at rr_ptr; nothing is granted while host owns RAM or in reset.
  always_comb begin
    logic [PTR_W:0] sum;
    logic [PTR_W:0] inc;
    sum         = '0;
    inc         = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (sum >= NUM_CORES_W) sum = sum - NUM_CORES_W;
      if (!grant_valid && core_req[sum[PTR_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = sum[PTR_W-1:0];
      end
    end
    if (reset || !run) begin
      grant_valid = 1'b0;
      grant_idx   = '0;
    end
    inc = {1'b0, grant_idx} + (PTR_W + 1)'(1);
    if (inc >= NUM_CORES_W) inc = '0;
    rr_next      = inc[PTR_W-1:0];
    grant_onehot = grant_valid ? (NUM_CORES'(1) << grant_idx) : '0;
  end

  assign core_ack = grant_onehot;

  always_comb begin
    ram_address     = '0;
    ram_write       = 1'b0;
    ram_write_data  = '0;
    addr_lsb_unused = ^host_address[1:0];
    for (int i = 0; i < NUM_CORES; i++) begin
      addr_lsb_unused = addr_lsb_unused ^ (^core_address[i*ADDRESS_WIDTH +: 2]);
    end
    if (!run) begin
      ram_address    = host_address[ADDRESS_WIDTH-1:2];
      ram_write      = host_write & ~reset;
      ram_write_data = host_write_data;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (grant_onehot[i]) begin
          ram_address    = core_address[i*ADDRESS_WIDTH+2 +: ADDRESS_WIDTH-2];
          ram_write      = core_write[i];
          ram_write_data = core_write_data[i*WORD_WIDTH +: WORD_WIDTH];
        end
      end
    end
  end

  assign conflict = run & ~reset & (|(core_req & (core_req - NUM_CORES'(1))));

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr       <= '0;
      host_pend    <= 1'b0;
      core_pend    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (grant_valid) rr_ptr <= rr_next;
      host_pend <= ~run & host_read & ~host_write;
      core_pend <= grant_onehot & ~core_write;
      if (conflict && (conflict_cnt != 32'hFFFF_FFFF)) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  // Return strobes come from registers, so reset must mask a read launched the cycle before.
  assign host_read_valid = host_pend & ~reset;
  assign core_read_valid = core_pend & {NUM_CORES{~reset}};
  assign host_read_data  = ram_read_data;
  assign core_read_data  = ram_read_data;
  assign conflict_count  = reset ? 32'd0 : conflict_cnt;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Bench for shared_ram_arbiter: directed scenarios then random traffic, checked
// against a rule-level model (round-robin by modulo scan, shadow memory, expected queue).
module tb_shared_ram_arbiter;
  localparam int WW  = 32;
  localparam int AW  = 16;
  localparam int NC  = 4;
  localparam int RAW = AW - 2;
  localparam int PW  = $clog2(NC);

  logic              clock;
  logic              reset;
  logic              run;
  logic [AW-1:0]     host_address;
  logic              host_write;
  logic              host_read;
  logic [WW-1:0]     host_write_data;
  logic [WW-1:0]     host_read_data;
  logic              host_read_valid;
  logic [NC-1:0]     core_req;
  logic [NC-1:0]     core_write;
  logic [NC*AW-1:0]  core_address;
  logic [NC*WW-1:0]  core_write_data;
  logic [NC-1:0]     core_ack;
  logic [WW-1:0]     core_read_data;
  logic [NC-1:0]     core_read_valid;
  logic [RAW-1:0]    ram_address;
  logic              ram_write;
  logic [WW-1:0]     ram_write_data;
  logic [WW-1:0]     ram_read_data;
  logic [31:0]       conflict_count;

  shared_ram_arbiter #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .NUM_CORES(NC)) dut (
    .clock(clock), .reset(reset), .run(run),
    .host_address(host_address), .host_write(host_write), .host_read(host_read),
    .host_write_data(host_write_data), .host_read_data(host_read_data),
    .host_read_valid(host_read_valid),
    .core_req(core_req), .core_write(core_write), .core_address(core_address),
    .core_write_data(core_write_data), .core_ack(core_ack),
    .core_read_data(core_read_data), .core_read_valid(core_read_valid),
    .ram_address(ram_address), .ram_write(ram_write), .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data), .conflict_count(conflict_count)
  );

  // ---------------- clock / block RAM ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [WW-1:0] mem [0:(1<<RAW)-1];
  always @(posedge clock) begin
    if (ram_write) mem[ram_address] <= ram_write_data;
    ram_read_data <= mem[ram_address];
  end

  // ---------------- reference model + scoreboard ----------------
  int            cmp_cnt = 0;
  int            fail_cnt = 0;
  int            m_rr = 0;
  int            m_core_pend = -1;
  bit            m_host_pend = 1'b0;
  logic [31:0]   m_count = 32'd0;
  logic [WW-1:0] shadow [int];
  logic [WW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    cmp_cnt++;
    assert (obs === expv) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [WW-1:0] shadow_rd(input int a);
    return shadow.exists(a) ? shadow[a] : '0;
  endfunction

  // Inputs are driven at the falling edge; step checks, then advances the model one clock.
  task automatic step();
    int            g;
    int            idx;
    int            e_addr;
    bit            e_wr;
    logic [WW-1:0] e_wd;
    logic [NC-1:0] e_ack;
    logic [WW-1:0] e_data;
    #1;
    g = -1;
    if (!reset && run) begin
      for (int k = 0; k < NC; k++) begin
        idx = (m_rr + k) % NC;
        if (g < 0 && core_req[idx[PW-1:0]]) g = idx;
      end
    end
    e_ack = (g >= 0) ? (NC'(1) << g) : '0;
    e_addr = 0; e_wr = 1'b0; e_wd = '0;
    if (!reset && !run) begin
      e_addr = int'(host_address) / 4; e_wr = host_write; e_wd = host_write_data;
    end else if (!reset && g >= 0) begin
      e_addr = int'(core_address[g*AW +: AW]) / 4;
      e_wr   = core_write[g];
      e_wd   = core_write_data[g*WW +: WW];
    end
    check("core_ack", 64'(core_ack), 64'(e_ack));
    check("ram_write", 64'(ram_write), 64'(e_wr));
    if (!reset) check("ram_address", 64'(ram_address), 64'(e_addr));
    if (e_wr) check("ram_write_data", 64'(ram_write_data), 64'(e_wd));
    check("host_read_valid", 64'(host_read_valid), 64'(m_host_pend && !reset));
    check("core_read_valid", 64'(core_read_valid),
          64'((m_core_pend >= 0 && !reset) ? (NC'(1) << m_core_pend) : NC'(0)));
    if (m_host_pend || m_core_pend >= 0) begin
      e_data = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      if (!reset && m_host_pend) check("host_read_data", 64'(host_read_data), 64'(e_data));
      if (!reset && m_core_pend >= 0) check("core_read_data", 64'(core_read_data), 64'(e_data));
    end
    check("conflict_count", 64'(conflict_count), 64'(reset ? 32'd0 : m_count));
    @(posedge clock);
    if (reset) begin
      m_rr = 0; m_host_pend = 1'b0; m_core_pend = -1; m_count = 32'd0;
    end else begin
      m_host_pend = !run && host_read && !host_write;
      if (m_host_pend) exp_q.push_back(shadow_rd(e_addr));
      m_core_pend = (g >= 0 && !core_write[g]) ? g : -1;
      if (m_core_pend >= 0) exp_q.push_back(shadow_rd(e_addr));
      if (e_wr) shadow[e_addr] = e_wd;
      if (g >= 0) m_rr = (g + 1) % NC;
      if (run && $countones(core_req) > 1 && m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    end
    @(negedge clock);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    host_address = '0; host_write = 1'b0; host_read = 1'b0; host_write_data = '0;
    core_req = '0; core_write = '0; core_address = '0; core_write_data = '0;
  endtask

  task automatic set_core(input int i, input bit wr, input logic [AW-1:0] a, input logic [WW-1:0] d);
    core_req[i] = 1'b1;
    core_write[i] = wr;
    core_address[i*AW +: AW] = a;
    core_write_data[i*WW +: WW] = d;
  endtask

  // ---------------- stimulus ----------------
  logic [NC-1:0] rr_seq [0:4];

  initial begin
    rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
    rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;
    for (int i = 0; i < (1 << RAW); i++) mem[i] = '0;
    idle(); reset = 1'b1; run = 1'b0;
    @(negedge clock);

    // Reset with host write and all cores requesting: nothing may reach the RAM.
    host_write = 1'b1; core_req = '1; run = 1'b1;
    #1;
    check("reset_ack", 64'(core_ack), 64'(0));
    check("reset_ram_write", 64'(ram_write), 64'(0));
    step();
    run = 1'b0; step();

    // Host write then read of 0xDEADBEEF at byte 0x0010.
    reset = 1'b0; idle();
    host_address = 16'h0010; host_write = 1'b1; host_write_data = 32'hDEAD_BEEF;
    #1; check("host_wr_addr", 64'(ram_address), 64'(4));
    step();
    idle(); host_address = 16'h0013; host_read = 1'b1;
    step();
    idle();
    #1;
    check("host_rd_valid", 64'(host_read_valid), 64'(1));
    check("host_rd_data", 64'(host_read_data), 64'(32'hDEAD_BEEF));
    step();
    // Read and write together: write happens, no return.
    host_address = 16'h0020; host_read = 1'b1; host_write = 1'b1; host_write_data = 32'h1234_5678;
    step();
    idle(); step();

    // All cores reading continuously from reset: grants 0,1,2,3,0; five conflicts counted.
    reset = 1'b1; run = 1'b1;
    for (int i = 0; i < NC; i++) set_core(i, 1'b0, AW'(16 * i), '0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1; check("rr_seq", 64'(core_ack), 64'(rr_seq[i]));
      step();
    end
    idle();
    #1; check("conflict_5", 64'(conflict_count), 64'(5));
    step();

    // Only core 2 reads 0x0010, then writes: valid only for the read.
    set_core(2, 1'b0, 16'h0010, '0);
    #1; check("c2_ack", 64'(core_ack), 64'(4'b0100));
    step();
    idle(); set_core(2, 1'b1, 16'h0040, 32'hCAFE_F00D);
    #1;
    check("c2_rd_valid", 64'(core_read_valid), 64'(4'b0100));
    check("c2_rd_data", 64'(core_read_data), 64'(32'hDEAD_BEEF));
    step();
    idle();
    #1; check("c2_wr_no_valid", 64'(core_read_valid), 64'(0));
    step();

    // Core 1 read granted, run dropped the next cycle.
    set_core(1, 1'b0, 16'h0040, '0);
    step();
    idle(); run = 1'b0; host_address = 16'h0084; host_write = 1'b1; host_write_data = 32'h0BAD_F00D;
    #1;
    check("c1_valid_after_run", 64'(core_read_valid), 64'(4'b0010));
    check("c1_data_after_run", 64'(core_read_data), 64'(32'hCAFE_F00D));
    check("host_owns_ram", 64'(ram_address), 64'(16'h0084 >> 2));
    step();

    // Core 0 read granted, reset the next cycle: return dropped, pointer back to 0.
    idle(); run = 1'b1; set_core(0, 1'b0, 16'h0010, '0);
    step();
    idle(); reset = 1'b1;
    #1; check("reset_drops_valid", 64'(core_read_valid), 64'(0));
    step();
    reset = 1'b0;
    for (int i = 0; i < NC; i++) set_core(i, 1'b0, AW'(4 * i), '0);
    #1; check("post_reset_grant", 64'(core_ack), 64'(4'b0001));
    step();

    // Counter preloaded near the top, sustained conflicts: saturates without wrapping.
    force dut.conflict_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.conflict_cnt;
    m_count = 32'hFFFF_FFFD;
    for (int i = 0; i < 5; i++) step();
    #1; check("conflict_saturate", 64'(conflict_count), 64'(32'hFFFF_FFFF));
    idle(); step();

    // Random traffic over a small address window.
    for (int c = 0; c < 800; c++) begin
      idle();
      reset = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 9) == 0) run = ~run;
      host_address = AW'($urandom_range(0, 127));
      host_write = ($urandom_range(0, 3) == 0);
      host_read = ($urandom_range(0, 1) == 1);
      host_write_data = $urandom;
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(0, 2) != 0)
          set_core(i, ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 127)), $urandom);
      end
      step();
    end
    idle(); reset = 1'b0; step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
